// File: rtl/alu_seq_display_if.sv
// Bus between the switch/LED front end and the sequential ALU.
// Signals:
//   start, op[2:0], a, b        request side (driven by master)
//   busy, done                  handshake status (driven by slave)
//   result, ovf, zero, neg, err registered result and flags
//   SEG                         signed one-digit 7-segment code
interface alu_seq_display_if #(
  parameter int NBITS = 4,
  parameter int SEG_W = 8
);
  logic             start;
  logic [2:0]       op;
  logic [NBITS-1:0] a;
  logic [NBITS-1:0] b;
  logic             busy;
  logic             done;
  logic [NBITS-1:0] result;
  logic             ovf;
  logic             zero;
  logic             neg;
  logic             err;
  logic [SEG_W-1:0] SEG;

  modport master (
    output start, op, a, b,
    input  busy, done, result, ovf, zero, neg, err, SEG
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, ovf, zero, neg, err, SEG
  );
endinterface

// File: rtl/alu_seq_display.sv
// Registered signed ALU with iterative shift-add multiply and a 7-segment
// display of the result.
// Ports:
//   clk_2  system clock, rising edge
//   reset  asynchronous, active-high
//   bus    alu_seq_display_if.slave: start/op/a/b in; busy/done/result/
//          ovf/zero/neg/err/SEG out
module alu_seq_display #(
  parameter int NBITS = 4,
  parameter int SEG_W = 8
) (
  input  logic              clk_2,
  input  logic              reset,
  alu_seq_display_if.slave  bus
);
  localparam int M  = NBITS - 1;
  localparam int PW = 2 * NBITS;
  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, DONE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        op_q, op_d;
  logic [NBITS-1:0]  a_q, a_d, b_q, b_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              mul_ld_q, mul_ld_d;
  logic [PW-1:0]     mcand_q, mcand_d, prod_q, prod_d;
  logic [NBITS-1:0]  mplier_q, mplier_d;
  logic [NBITS-1:0]  result_q, result_d;
  logic              ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d, err_q, err_d;

  logic [NBITS-1:0]  r;
  logic              v, e;
  logic [PW-1:0]     p_nxt, p_s;
  logic [7:0]        mag8, seg8, digit;

  // Magnitude as unsigned NBITS; the most-negative value maps to 2^(NBITS-1).
  function automatic logic [NBITS-1:0] mag(input logic [NBITS-1:0] x);
    return x[M] ? (~x + NBITS'(1)) : x;
  endfunction

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      cnt_q    <= '0;
      mul_ld_q <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      result_q <= '0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b1;
      neg_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      cnt_q    <= cnt_d;
      mul_ld_q <= mul_ld_d;
      mcand_q  <= mcand_d;
      prod_q   <= prod_d;
      mplier_q <= mplier_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    cnt_d    = cnt_q;
    mul_ld_d = mul_ld_q;
    mcand_d  = mcand_q;
    prod_d   = prod_q;
    mplier_d = mplier_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    err_d    = err_q;
    r        = '0;
    v        = 1'b0;
    e        = 1'b0;

    // Last shift-add step and sign application, used on the final iteration.
    p_nxt = prod_q + (mplier_q[0] ? mcand_q : '0);
    p_s   = (a_q[M] ^ b_q[M]) ? (~p_nxt + PW'(1)) : p_nxt;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          op_d     = bus.op;
          a_d      = bus.a;
          b_d      = bus.b;
          mul_ld_d = 1'b1;
          state_d  = (bus.op == 3'b100) ? MUL : EXEC;
        end
      end
      EXEC: begin
        case (op_q)
          3'b000: begin
            r = a_q + b_q;
            v = (a_q[M] == b_q[M]) && (r[M] != a_q[M]);
          end
          3'b001: begin
            r = a_q - b_q;
            v = (a_q[M] != b_q[M]) && (r[M] != a_q[M]);
          end
          3'b010: r = a_q & b_q;
          3'b011: r = a_q | b_q;
          3'b101: r = a_q ^ b_q;
          3'b110: r = NBITS'($signed(a_q) < $signed(b_q));
          3'b111: e = 1'b1;
          default: r = '0;
        endcase
        result_d = r;
        ovf_d    = v;
        err_d    = e;
        zero_d   = (r == '0);
        neg_d    = r[M];
        state_d  = DONE;
      end
      MUL: begin
        // The first MUL cycle loads operand magnitudes; the NBITS shift-add
        // iterations (cnt 0..NBITS-1) follow.
        if (mul_ld_q) begin
          mcand_d  = PW'(mag(a_q));
          mplier_d = mag(b_q);
          prod_d   = '0;
          cnt_d    = '0;
          mul_ld_d = 1'b0;
        end else begin
          prod_d   = p_nxt;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CW'(M)) begin
            result_d = p_s[M:0];
            ovf_d    = (p_s[PW-1:NBITS] != {NBITS{p_s[M]}});
            err_d    = 1'b0;
            zero_d   = (p_s[M:0] == '0);
            neg_d    = p_s[M];
            state_d  = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mag8 = 8'(mag(result_q));
    case (mag8)
      8'd0:    digit = 8'h3F;
      8'd1:    digit = 8'h06;
      8'd2:    digit = 8'h5B;
      8'd3:    digit = 8'h4F;
      8'd4:    digit = 8'h66;
      8'd5:    digit = 8'h6D;
      8'd6:    digit = 8'h7D;
      8'd7:    digit = 8'h07;
      8'd8:    digit = 8'h7F;
      8'd9:    digit = 8'h6F;
      default: digit = 8'h00;
    endcase
    if (ovf_q || (mag8 > 8'd9)) seg8 = 8'h80;
    else                        seg8 = digit | (result_q[M] ? 8'h80 : 8'h00);
  end

  assign bus.busy   = (state_q == EXEC) || (state_q == MUL);
  assign bus.done   = (state_q == DONE);
  assign bus.result = result_q;
  assign bus.ovf    = ovf_q;
  assign bus.zero   = zero_q;
  assign bus.neg    = neg_q;
  assign bus.err    = err_q;
  assign bus.SEG    = SEG_W'(seg8);
endmodule

// File: tb/tb_alu_seq_display.sv
// Directed, table-driven bench for alu_seq_display at NBITS=4.
module tb_alu_seq_display;
  localparam int NB = 4;
  localparam int SW = 8;

  logic clk_2 = 1'b0;
  logic reset;
  always #5 clk_2 = ~clk_2;

  alu_seq_display_if #(.NBITS(NB), .SEG_W(SW)) bus ();

  alu_seq_display #(.NBITS(NB), .SEG_W(SW)) dut (
    .clk_2 (clk_2),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] r;
    logic       ovf;
    logic       err;
    logic [7:0] seg;
    int         lat;
  } vec_t;

  vec_t vt[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issue one op, scramble inputs while busy, wait for done (bounded).
  task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                        output int lat, output logic busy_ok);
    @(negedge clk_2);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    lat = 0;
    busy_ok = 1'b1;
    do begin
      @(negedge clk_2);
      bus.start = 1'b0; bus.op = ~op; bus.a = ~a; bus.b = b ^ 4'h5;
      lat++;
      if (!bus.done && !bus.busy) busy_ok = 1'b0;
    end while (!bus.done && lat < 30);
  endtask

  int   lat;
  logic bok;
  logic seen;
  logic [5:0] pat;

  initial begin
    vt.push_back('{3'b000, 4'h3, 4'h2, 4'h5, 1'b0, 1'b0, 8'h6D, 2});
    vt.push_back('{3'b000, 4'h7, 4'h1, 4'h8, 1'b1, 1'b0, 8'h80, 2});
    vt.push_back('{3'b001, 4'h2, 4'h5, 4'hD, 1'b0, 1'b0, 8'hCF, 2});
    vt.push_back('{3'b100, 4'hE, 4'h3, 4'hA, 1'b0, 1'b0, 8'hFD, 6});
    vt.push_back('{3'b100, 4'h3, 4'h3, 4'h9, 1'b1, 1'b0, 8'h80, 6});
    vt.push_back('{3'b100, 4'hC, 4'h2, 4'h8, 1'b0, 1'b0, 8'hFF, 6});
    vt.push_back('{3'b111, 4'h5, 4'h5, 4'h0, 1'b0, 1'b1, 8'h3F, 2});
    vt.push_back('{3'b010, 4'hC, 4'h6, 4'h4, 1'b0, 1'b0, 8'h66, 2});
    vt.push_back('{3'b110, 4'hF, 4'h1, 4'h1, 1'b0, 1'b0, 8'h06, 2});
    vt.push_back('{3'b011, 4'h9, 4'h4, 4'hD, 1'b0, 1'b0, 8'hCF, 2});
    vt.push_back('{3'b101, 4'h5, 4'h3, 4'h6, 1'b0, 1'b0, 8'h7D, 2});
    vt.push_back('{3'b001, 4'h8, 4'h1, 4'h7, 1'b1, 1'b0, 8'h80, 2});
    vt.push_back('{3'b110, 4'h1, 4'hF, 4'h0, 1'b0, 1'b0, 8'h3F, 2});
    vt.push_back('{3'b100, 4'h7, 4'h8, 4'h8, 1'b1, 1'b0, 8'h80, 6});
    vt.push_back('{3'b100, 4'h0, 4'h5, 4'h0, 1'b0, 1'b0, 8'h3F, 6});
    vt.push_back('{3'b000, 4'hF, 4'hF, 4'hE, 1'b0, 1'b0, 8'hDB, 2});
    vt.push_back('{3'b100, 4'hF, 4'hF, 4'h1, 1'b0, 1'b0, 8'h06, 6});
    vt.push_back('{3'b001, 4'h0, 4'h8, 4'h8, 1'b1, 1'b0, 8'h80, 2});

    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0;
    #3;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_result", bus.result, 0);
    chk("rst_zero", bus.zero, 1);
    chk("rst_seg", bus.SEG, 8'h3F);
    @(negedge clk_2);
    reset = 1'b0;

    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, lat, bok);
      chk($sformatf("v%0d_lat", i), lat, vt[i].lat);
      chk($sformatf("v%0d_busy_during", i), bok, 1);
      chk($sformatf("v%0d_busy_at_done", i), bus.busy, 0);
      chk($sformatf("v%0d_result", i), bus.result, vt[i].r);
      chk($sformatf("v%0d_ovf", i), bus.ovf, vt[i].ovf);
      chk($sformatf("v%0d_err", i), bus.err, vt[i].err);
      chk($sformatf("v%0d_zero", i), bus.zero, (vt[i].r == 4'h0));
      chk($sformatf("v%0d_neg", i), bus.neg, vt[i].r[3]);
      chk($sformatf("v%0d_seg", i), bus.SEG, vt[i].seg);
      @(negedge clk_2);
      chk($sformatf("v%0d_done_pulse", i), bus.done, 0);
      chk($sformatf("v%0d_hold", i), bus.result, vt[i].r);
    end

    // start pulsed with ADD in the middle of a MUL must be ignored
    @(negedge clk_2);
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 4'hE; bus.b = 4'h3;
    @(negedge clk_2); bus.start = 1'b0;
    @(negedge clk_2); bus.start = 1'b1; bus.op = 3'b000; bus.a = 4'h1; bus.b = 4'h1;
    @(negedge clk_2); bus.start = 1'b0;
    lat = 3;
    while (!bus.done && lat < 30) begin
      @(negedge clk_2);
      lat++;
    end
    chk("midmul_lat", lat, 6);
    chk("midmul_result", bus.result, 4'hA);
    @(negedge clk_2);
    chk("midmul_no_second_op", bus.busy, 0);
    repeat (3) @(negedge clk_2);
    chk("midmul_result_hold", bus.result, 4'hA);

    // start held through DONE: accepted again only in the following IDLE
    @(negedge clk_2);
    bus.start = 1'b1; bus.op = 3'b000; bus.a = 4'h1; bus.b = 4'h2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_2);
      pat[i] = bus.done;
    end
    bus.start = 1'b0;
    chk("b2b_done_pattern", pat, 6'b010010);
    chk("b2b_result", bus.result, 4'h3);
    repeat (3) @(negedge clk_2);

    // asynchronous reset while MUL is at cnt=2
    run_op(3'b000, 4'h3, 4'h2, lat, bok);
    chk("pre_rst_result", bus.result, 4'h5);
    @(negedge clk_2);
    bus.start = 1'b1; bus.op = 3'b100; bus.a = 4'h5; bus.b = 4'h3;
    @(negedge clk_2); bus.start = 1'b0;
    repeat (3) @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_done", bus.done, 0);
    chk("arst_result", bus.result, 0);
    chk("arst_zero", bus.zero, 1);
    chk("arst_seg", bus.SEG, 8'h3F);
    @(negedge clk_2);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk_2);
      if (bus.done || bus.busy) seen = 1'b1;
    end
    chk("arst_no_done", seen, 0);
    run_op(3'b000, 4'h1, 4'h1, lat, bok);
    chk("post_rst_lat", lat, 2);
    chk("post_rst_result", bus.result, 4'h2);
    chk("post_rst_seg", bus.SEG, 8'h5B);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
